// File: rtl/score_display_driver_pkg.sv
// Shared game types and seven-segment glyph constants.
// Segment vectors are active high, ordered {g,f,e,d,c,b,a}.
package score_display_driver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WIN  = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_ERR   = 7'b1111001;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b0111111,   // 0
      7'b0000110,   // 1
      7'b1011011,   // 2
      7'b1001111,   // 3
      7'b1100110,   // 4
      7'b1101101,   // 5
      7'b1111101,   // 6
      7'b0000111,   // 7
      7'b1111111,   // 8
      7'b1101111    // 9
   };

endpackage

// File: rtl/score_display_driver_seg_decoder.sv
// BCD digit to active-high seven-segment pattern; non-BCD values show E.
module seg_decoder
   import score_display_driver_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] pattern
);

   // Table lookup for 0..9, error glyph for anything else.
   always_comb begin
      pattern = SEG_ERR;
      if (value <= 4'd9) begin
         pattern = SEG_DIGIT[value];
      end
   end

endmodule

// File: rtl/score_display_driver.sv
// Two-digit multiplexed seven-segment driver for the score counter.
// Digits are snapshotted once per frame so a slot pair never mixes scores.
module score_display_driver
   import score_display_driver_pkg::*;
#(
   parameter int SCAN_DIV       = 12000,
   parameter int BLINK_DIV      = 6000000,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  state_t     state,
   input  logic [3:0] bcd_ones,
   input  logic [3:0] bcd_tens,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] digit_en
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
   logic               digit_sel_q, digit_sel_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_on_q,  blink_on_d;
   logic [3:0]         snap_ones_q, snap_ones_d;
   logic [3:0]         snap_tens_q, snap_tens_d;
   state_t             prev_state_q, prev_state_d;
   logic               snap_pend_q, snap_pend_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;
   logic [1:0]         digit_en_q, digit_en_d;

   logic               scan_wrap;
   logic               over_entry;
   logic [3:0]         dec_val;
   logic [6:0]         dec_pattern;
   logic [1:0]         slot_en;
   logic               tens_dark;

   assign dec_val = digit_sel_q ? snap_tens_q : snap_ones_q;

   seg_decoder u_seg_decoder (
      .value   (dec_val),
      .pattern (dec_pattern)
   );

   // Scan timer, frame snapshot and blink timer next-state.
   always_comb begin
      scan_wrap    = (scan_cnt_q == SCAN_LAST);
      scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      digit_sel_d  = digit_sel_q ^ scan_wrap;

      snap_ones_d  = snap_ones_q;
      snap_tens_d  = snap_tens_q;
      snap_pend_d  = 1'b0;
      // First cycle out of reset, or tens->ones wrap (frame start).
      if (snap_pend_q || (scan_wrap && digit_sel_q)) begin
         snap_ones_d = bcd_ones;
         snap_tens_d = bcd_tens;
      end

      over_entry   = (state == OVER) && (prev_state_q != OVER);
      prev_state_d = state;

      // OVER entry restarts the blink in its "on" phase, overriding a wrap.
      if (over_entry) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
         blink_on_d  = blink_on_q;
      end
   end

   // Glyph selection for the active slot, before polarity.
   always_comb begin
      slot_en    = digit_sel_q ? 2'b10 : 2'b01;
      tens_dark  = digit_sel_q && (snap_tens_q == 4'd0);
      seg_d      = SEG_BLANK;
      dp_d       = 1'b0;
      digit_en_d = 2'b00;
      case (state)
         RUN, WIN, OVER: begin
            if (!tens_dark && ((state != OVER) || blink_on_q)) begin
               digit_en_d = slot_en;
               seg_d      = dec_pattern;
               dp_d       = (state == WIN);
            end
         end
         default: begin
            digit_en_d = slot_en;
            seg_d      = SEG_DASH;
         end
      endcase
   end

   // All state and the output register; polarity applied on the way in.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_cnt_q   <= '0;
         digit_sel_q  <= 1'b0;
         blink_cnt_q  <= '0;
         blink_on_q   <= 1'b1;
         snap_ones_q  <= 4'd0;
         snap_tens_q  <= 4'd0;
         prev_state_q <= IDLE;
         snap_pend_q  <= 1'b1;
         seg_q        <= SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
         dp_q         <= SEG_ACTIVE_LOW;
         digit_en_q   <= 2'b00;
      end else begin
         scan_cnt_q   <= scan_cnt_d;
         digit_sel_q  <= digit_sel_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_on_q   <= blink_on_d;
         snap_ones_q  <= snap_ones_d;
         snap_tens_q  <= snap_tens_d;
         prev_state_q <= prev_state_d;
         snap_pend_q  <= snap_pend_d;
         seg_q        <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
         dp_q         <= SEG_ACTIVE_LOW ? ~dp_d : dp_d;
         digit_en_q   <= digit_en_d;
      end
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign digit_en = digit_en_q;

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Consumer end of the score counter's BCD interface. Takes `bcd_tens`/`bcd_ones` and the game `state`, and drives a two-digit, time-multiplexed seven-segment display.
- Features: per-frame digit snapshot, leading-zero blanking, an IDLE dash pattern, a WIN indicator, an OVER blink, and an error glyph for invalid BCD.
- Sits between score_counter and the board pins, in the same clock domain.

Parameters:
- SCAN_DIV, 12000: clk cycles per digit slot (1 kHz digit toggle at 12 MHz).
- BLINK_DIV, 6000000: clk cycles per blink half-period (0.5 s at 12 MHz).
- SEG_ACTIVE_LOW, 0: when 1, `seg` and `dp` are inverted at the output register (blank = all 1s).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- state  input  state_t  game state (IDLE, RUN, WIN, OVER)
- bcd_ones  input  4  units digit from score_counter
- bcd_tens  input  4  tens digit from score_counter
- seg  output  7  segments {g,f,e,d,c,b,a}
- dp  output  1  decimal point of the active digit
- digit_en  output  2  one-hot digit enable, active high; [0]=ones, [1]=tens; 00 = dark slot

Behaviour:
- Reset (reset==0 at a clk edge):
  - scan_cnt=0, digit_sel=0, blink_cnt=0, blink_on=1.
  - snap_ones=0, snap_tens=0, prev_state=IDLE.
  - Outputs: digit_en=00, seg=blank, dp=off (polarity applied).
- Reset mid-operation follows the same rule; no state survives it.
- Scan timer:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - At the wrap cycle digit_sel toggles.
- Snapshot:
  - On the wrap where digit_sel goes 1->0 (frame start), snap_ones/snap_tens capture bcd_ones/bcd_tens.
  - Also captured on the first cycle after reset release.
  - Input changes mid-frame never produce a mixed display.
  - Worst-case display latency from input change is 2*SCAN_DIV+1 cycles.
- Blink timer:
  - blink_cnt counts 0..BLINK_DIV-1; blink_on toggles on wrap.
  - On entry to OVER (state==OVER && prev_state!=OVER): blink_cnt=0, blink_on=1.
  - prev_state is updated every cycle.
- Glyph selection, per active slot from the snapshot:
  - IDLE: both slots show dash (g only), dp off.
  - RUN: ones slot shows snap_ones. Tens slot shows snap_tens, except when snap_tens==0, where the slot is dark (digit_en=00 for that slot, seg blank).
  - WIN: shows snapshot as in RUN, with dp on in both slots.
  - OVER: shows snapshot as in RUN while blink_on=1; digit_en=00 and seg blank while blink_on=0.
  - Unknown state value: same as IDLE.
- Decoding:
  - Digit value >9: glyph E (a,d,e,f,g).
  - 0..9: standard glyphs, e.g. 0=a-f, 1=b,c, 7=a,b,c, 8=all.
- Output timing:
  - seg, dp and digit_en are registered.
  - They reflect digit_sel, snapshot and blink_on one cycle after those change.
  - Never glitch within a slot.
  - digit_en is never 11.
- State changes take effect on the next registered output; no snapshot is required for them.
- Simultaneous events:
  - Frame-start snapshot and OVER entry in the same cycle: both happen.
  - Blink wrap and OVER entry in the same cycle: OVER-entry reset wins.

Decomposition:
- state_t already lives in the shared game package. Add these constants there:
  - SEG_BLANK
  - SEG_DASH
  - SEG_ERR
  - the 10-entry SEG_DIGIT array
- One combinational sub-module, seg_decoder: 4-bit value in, 7-bit active-high pattern out, E for >9.
- Polarity inversion stays in the top output register.

Test Plan (SCAN_DIV=4, BLINK_DIV=16):
- Reset held 3 cycles, then released with state=RUN, tens=4, ones=2:
  - During reset: digit_en=00, seg=0.
  - After release: digit_en alternates 01/10 every 4 cycles, with seg=2-glyph (7'b1011011) / 4-glyph (7'b1100110).
- RUN, tens=0, ones=7: ones slot seg=7'b0000111; tens slot digit_en=00, seg=0.
- Change inputs from 37 to 38 in the middle of the ones slot: the display keeps 37 until the next frame start, then shows 38. No frame shows 3 with 8 mixed.
- state=IDLE with any inputs: both slots seg=7'b1000000, dp=0. Then state=WIN with 99: both slots show 9, dp=1.
- RUN 55, then OVER:
  - Digits shown for exactly 16 cycles, dark for 16, repeating.
  - Re-entering OVER after a RUN interval restarts with the "on" phase.
- RUN with bcd_ones=4'hC: ones slot seg=7'b1111001 (E). Then SEG_ACTIVE_LOW=1 with the same stimulus: seg=7'b0000110 and blank slots read 7'b1111111.
